// File: rtl/exec_sequencer.sv
// Instruction-issue controller: edge-detects the step/run buttons and feeds one
// instruction at a time (switches or program ROM) to the datapath over valid/ready.
module exec_sequencer #(
   parameter int PC_W     = 4,
   parameter int PROG_LEN = 16,
   parameter int INSTR_W  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         button,
   input  logic [INSTR_W-1:0] switches,
   output logic [PC_W-1:0]    rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               dp_ready,
   output logic               busy
);

   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

   typedef enum logic [2:0] {IDLE, STEP, FETCH, WAIT, ISSUE} state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [1:0]         btn_q, btn_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic               busy_q, busy_d;
   logic [1:0]         rise;
   logic               transfer;

   always_comb begin
      rise     = button & ~btn_q;
      transfer = instr_valid_q & dp_ready;
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      btn_d    = button;

      case (state_q)
         IDLE: begin
            // Run wins when both buttons rise in the same cycle.
            if (rise[0]) begin
               pc_d    = '0;
               state_d = FETCH;
            end else if (rise[1]) begin
               instr_d = switches;
               state_d = STEP;
            end
         end
         STEP: begin
            if (transfer) state_d = IDLE;
         end
         FETCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            instr_d = rom_data;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (transfer) begin
               if (pc_q == PC_LAST) begin
                  state_d = IDLE;
               end else begin
                  pc_d    = pc_q + PC_W'(1);
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      instr_valid_d = (state_d == STEP) || (state_d == ISSUE);
      busy_d        = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         btn_q         <= 2'b00;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         btn_q         <= btn_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign rom_addr    = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign busy        = busy_q;

endmodule
